// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: register index width, FSM state encoding and
// the canned stage-control words the hazard sequencer selects between.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W = 5;
    typedef logic [REG_W-1:0] reg_idx_t;

    // r0 is hard-wired zero, so a load targeting it can never create a hazard
    localparam reg_idx_t ZERO_REG = '0;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    // One control word per cycle: stage write enables, NOP insertion, error pulse
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic memwb_we;
        logic ifid_flush;
        logic idex_bubble;
        logic memwb_bubble;
        logic mem_error;
    } hz_ctrl_t;

    // Everything frozen, no NOPs (used while Reset is asserted)
    localparam hz_ctrl_t CTRL_HOLD = '{default: 1'b0};

    // Normal advance of every stage
    localparam hz_ctrl_t CTRL_ADVANCE = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
                                          exmem_we: 1'b1, memwb_we: 1'b1,
                                          default: 1'b0};

    // Memory not ready: freeze the front, drain a NOP into MEM/WB
    localparam hz_ctrl_t CTRL_MEM_STALL = '{memwb_we: 1'b1, memwb_bubble: 1'b1,
                                            default: 1'b0};

    // Taken branch: advance, kill the two wrong-path instructions
    localparam hz_ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
                                         exmem_we: 1'b1, memwb_we: 1'b1,
                                         ifid_flush: 1'b1, idex_bubble: 1'b1,
                                         default: 1'b0};

    // Load-use: hold PC and IF/ID, push a NOP into ID/EX
    localparam hz_ctrl_t CTRL_LOAD_USE = '{idex_we: 1'b1, idex_bubble: 1'b1,
                                           exmem_we: 1'b1, memwb_we: 1'b1,
                                           default: 1'b0};

    // Memory timeout: forced release with error pulse
    localparam hz_ctrl_t CTRL_TIMEOUT = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
                                          exmem_we: 1'b1, memwb_we: 1'b1,
                                          mem_error: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath and the stall/flush sequencer.
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int PERF_W = 32
);
    // Hazard information latched in the pipeline registers
    logic              EXMEM_MemRead;
    logic              EXMEM_MemWrite;
    logic              MemReady;
    logic              IDEX_MemRead;
    reg_idx_t          IDEX_RegDest;
    reg_idx_t          IFID_Rs;
    reg_idx_t          IFID_Rt;
    logic              IFID_UsesRt;
    logic              BranchTaken;

    // Stage controls returned to the datapath
    logic              PC_WE;
    logic              IFID_WE;
    logic              IDEX_WE;
    logic              EXMEM_WE;
    logic              MEMWB_WE;
    logic              IFID_Flush;
    logic              IDEX_Bubble;
    logic              MEMWB_Bubble;
    logic              MemError;
    logic [PERF_W-1:0] StallCycles;

    // Datapath side
    modport master (
        output EXMEM_MemRead, EXMEM_MemWrite, MemReady, IDEX_MemRead, IDEX_RegDest,
               IFID_Rs, IFID_Rt, IFID_UsesRt, BranchTaken,
        input  PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE, IFID_Flush, IDEX_Bubble,
               MEMWB_Bubble, MemError, StallCycles
    );

    // Sequencer side
    modport slave (
        input  EXMEM_MemRead, EXMEM_MemWrite, MemReady, IDEX_MemRead, IDEX_RegDest,
               IFID_Rs, IFID_Rt, IFID_UsesRt, BranchTaken,
        output PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE, IFID_Flush, IDEX_Bubble,
               MEMWB_Bubble, MemError, StallCycles
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic     IDEX_MemRead,
    input  reg_idx_t IDEX_RegDest,
    input  reg_idx_t IFID_Rs,
    input  reg_idx_t IFID_Rt,
    input  logic     IFID_UsesRt,
    output logic     LoadUse
);
    reg_idx_t   src_idx [2];
    logic [1:0] src_used;
    logic [1:0] src_match;

    // Rs is always read; Rt only for instructions that actually consume it
    assign src_idx[0] = IFID_Rs;
    assign src_idx[1] = IFID_Rt;
    assign src_used   = {IFID_UsesRt, 1'b1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_used[gi] && (src_idx[gi] == IDEX_RegDest);
        end
    endgenerate

    assign LoadUse = IDEX_MemRead && (IDEX_RegDest != ZERO_REG) && (|src_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: arbitrates memory waits, taken branches and
// load-use hazards into per-stage write enables and NOP insertion.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4,
    parameter int PERF_W      = 32
) (
    input  logic                   Clock,
    input  logic                   Reset,
    pipeline_hazard_ctrl_if.slave  hz
);
    state_t            state_reg, state_next;
    logic [TMO_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [PERF_W-1:0] stall_cycles_reg;
    hz_ctrl_t          ctrl;
    logic              mem_acc;
    logic              load_use;
    logic              wait_expired;

    assign mem_acc      = hz.EXMEM_MemRead | hz.EXMEM_MemWrite;
    assign wait_expired = (wait_cnt_reg == TMO_W'(MEM_TIMEOUT));

    pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
        .IDEX_MemRead (hz.IDEX_MemRead),
        .IDEX_RegDest (hz.IDEX_RegDest),
        .IFID_Rs      (hz.IFID_Rs),
        .IFID_Rt      (hz.IFID_Rt),
        .IFID_UsesRt  (hz.IFID_UsesRt),
        .LoadUse      (load_use)
    );

    // State, wait counter and saturating stall counter
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_reg        <= ST_RUN;
            wait_cnt_reg     <= '0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (!ctrl.pc_we && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + PERF_W'(1);
            end
        end
    end

    // Next state: enter MEM_WAIT on an unready access, leave on ready or timeout
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (mem_acc && !hz.MemReady) begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = TMO_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (hz.MemReady || wait_expired) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + TMO_W'(1);
                end
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Outputs: memory stall beats branch beats load-use; branch and load-use
    // are not looked at while waiting because EX is frozen
    always_comb begin
        ctrl = CTRL_HOLD;
        if (Reset) begin
            case (state_reg)
                ST_RUN: begin
                    if (mem_acc && !hz.MemReady) ctrl = CTRL_MEM_STALL;
                    else if (hz.BranchTaken)     ctrl = CTRL_BRANCH;
                    else if (load_use)           ctrl = CTRL_LOAD_USE;
                    else                         ctrl = CTRL_ADVANCE;
                end
                ST_MEM_WAIT: begin
                    if (hz.MemReady)             ctrl = CTRL_ADVANCE;
                    else if (wait_expired)       ctrl = CTRL_TIMEOUT;
                    else                         ctrl = CTRL_MEM_STALL;
                end
                default:                         ctrl = CTRL_HOLD;
            endcase
        end
    end

    assign hz.PC_WE        = ctrl.pc_we;
    assign hz.IFID_WE      = ctrl.ifid_we;
    assign hz.IDEX_WE      = ctrl.idex_we;
    assign hz.EXMEM_WE     = ctrl.exmem_we;
    assign hz.MEMWB_WE     = ctrl.memwb_we;
    assign hz.IFID_Flush   = ctrl.ifid_flush;
    assign hz.IDEX_Bubble  = ctrl.idex_bubble;
    assign hz.MEMWB_Bubble = ctrl.memwb_bubble;
    assign hz.MemError     = ctrl.mem_error;
    assign hz.StallCycles  = stall_cycles_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for single-cycle RUN
// decisions plus hand-written memory-wait, timeout, priority and reset sequences.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    // Expected control words, bit order:
    // {PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE, IFID_Flush, IDEX_Bubble, MEMWB_Bubble, MemError}
    localparam logic [8:0] E_RST = 9'b00000_000_0;
    localparam logic [8:0] E_ADV = 9'b11111_000_0;
    localparam logic [8:0] E_BR  = 9'b11111_110_0;
    localparam logic [8:0] E_LU  = 9'b00111_010_0;
    localparam logic [8:0] E_MS  = 9'b00001_001_0;
    localparam logic [8:0] E_TO  = 9'b11111_000_1;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    pipeline_hazard_ctrl_if #(.PERF_W(32)) hz ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (15),
        .TMO_W       (4),
        .PERF_W      (32)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .hz    (hz)
    );

    int errors    = 0;
    int checks    = 0;
    int exp_stall = 0;

    typedef struct {
        string      name;
        logic       mrd;
        logic       mwr;
        logic       rdy;
        logic       idex_rd;
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input string name, input logic mrd, input logic mwr,
                                input logic rdy, input logic idex_rd, input logic [4:0] dest,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic uses_rt, input logic br, input logic [8:0] exp);
        vec_t v;
        v.name = name; v.mrd = mrd; v.mwr = mwr; v.rdy = rdy; v.idex_rd = idex_rd;
        v.dest = dest; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input logic mrd, input logic mwr, input logic rdy,
                         input logic idex_rd, input logic [4:0] dest, input logic [4:0] rs,
                         input logic [4:0] rt, input logic uses_rt, input logic br);
        hz.EXMEM_MemRead  = mrd;
        hz.EXMEM_MemWrite = mwr;
        hz.MemReady       = rdy;
        hz.IDEX_MemRead   = idex_rd;
        hz.IDEX_RegDest   = dest;
        hz.IFID_Rs        = rs;
        hz.IFID_Rt        = rt;
        hz.IFID_UsesRt    = uses_rt;
        hz.BranchTaken    = br;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
    endtask

    task automatic check_ctrl(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = {hz.PC_WE, hz.IFID_WE, hz.IDEX_WE, hz.EXMEM_WE, hz.MEMWB_WE,
               hz.IFID_Flush, hz.IDEX_Bubble, hz.MEMWB_Bubble, hz.MemError};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: ctrl got %b required %b", name, got, exp);
        end else begin
            $display("ok   %s: ctrl %b", name, got);
        end
    endtask

    task automatic check_stall(input string name);
        checks++;
        if (hz.StallCycles !== 32'(exp_stall)) begin
            errors++;
            $display("FAIL %s: StallCycles got %0d required %0d", name, hz.StallCycles, exp_stall);
        end else begin
            $display("ok   %s: StallCycles %0d", name, hz.StallCycles);
        end
    endtask

    initial begin
        //                name            mrd   mwr   rdy   idrd  dest   rs     rt     usesRt br    expected
        vecs[0]  = mk("idle",             1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd1,  5'd2,  1'b1, 1'b0, E_ADV);
        vecs[1]  = mk("lu_rs_match",      1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  5'd8,  5'd3,  1'b0, 1'b0, E_LU);
        vecs[2]  = mk("lu_dest_zero",     1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, E_ADV);
        vecs[3]  = mk("lu_rt_used",       1'b0, 1'b0, 1'b0, 1'b1, 5'd17, 5'd4,  5'd17, 1'b1, 1'b0, E_LU);
        vecs[4]  = mk("lu_rt_unused",     1'b0, 1'b0, 1'b0, 1'b1, 5'd17, 5'd4,  5'd17, 1'b0, 1'b0, E_ADV);
        vecs[5]  = mk("no_load_match",    1'b0, 1'b0, 1'b0, 1'b0, 5'd9,  5'd9,  5'd9,  1'b1, 1'b0, E_ADV);
        vecs[6]  = mk("branch",           1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd1,  5'd2,  1'b1, 1'b1, E_BR);
        vecs[7]  = mk("branch_over_lu",   1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  5'd5,  5'd6,  1'b0, 1'b1, E_BR);
        vecs[8]  = mk("zero_wait_rd",     1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  5'd1,  5'd2,  1'b1, 1'b0, E_ADV);
        vecs[9]  = mk("zero_wait_wr_br",  1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  5'd1,  5'd2,  1'b1, 1'b1, E_BR);
        vecs[10] = mk("ready_no_access",  1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  5'd1,  5'd2,  1'b1, 1'b0, E_ADV);
        vecs[11] = mk("zero_wait_lu",     1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 5'd2,  5'd31, 1'b1, 1'b0, E_LU);

        // Reset: hazardous inputs must not leak through while Reset is low
        Reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1);
        @(negedge Clock); #1;
        check_ctrl("reset_outputs", E_RST);
        @(posedge Clock); #1;
        check_stall("reset_stall");
        @(negedge Clock);
        drive_idle();
        Reset = 1'b1;

        // Table: single-cycle decisions in RUN
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            drive(vecs[i].mrd, vecs[i].mwr, vecs[i].rdy, vecs[i].idex_rd, vecs[i].dest,
                  vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].br);
            #1;
            check_ctrl(vecs[i].name, vecs[i].exp);
            if (!vecs[i].exp[8]) exp_stall++;
            @(posedge Clock); #1;
            check_stall({vecs[i].name, "_stall"});
        end

        // Memory wait: MemReady arrives on the 4th cycle -> 3 stall cycles
        for (int c = 1; c <= 3; c++) begin
            @(negedge Clock);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
            #1;
            check_ctrl($sformatf("memwait_c%0d", c), E_MS);
        end
        @(negedge Clock);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
        #1;
        check_ctrl("memwait_release", E_ADV);
        exp_stall += 3;
        @(negedge Clock);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
        #1;
        check_ctrl("memwait_back_run", E_BR);
        @(posedge Clock); #1;
        check_stall("memwait_stall");

        // Timeout: MemReady never comes, forced release with MemError on cycle 16
        for (int c = 1; c <= 16; c++) begin
            @(negedge Clock);
            drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
            #1;
            check_ctrl($sformatf("timeout_c%0d", c), (c == 16) ? E_TO : E_MS);
        end
        exp_stall += 15;
        @(negedge Clock);
        drive_idle();
        #1;
        check_ctrl("timeout_after", E_ADV);
        @(posedge Clock); #1;
        check_stall("timeout_stall");

        // Priority: branch held during a memory wait is ignored until after release
        for (int c = 1; c <= 2; c++) begin
            @(negedge Clock);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
            #1;
            check_ctrl($sformatf("prio_wait_c%0d", c), E_MS);
        end
        @(negedge Clock);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
        #1;
        check_ctrl("prio_release", E_ADV);
        @(negedge Clock);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
        #1;
        check_ctrl("prio_flush", E_BR);
        exp_stall += 2;
        @(posedge Clock); #1;
        check_stall("prio_stall");

        // Reset on wait cycle 2: outputs drop at once, counters clear next edge
        for (int c = 1; c <= 3; c++) begin
            @(negedge Clock);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
            #1;
            check_ctrl($sformatf("rstwait_c%0d", c), E_MS);
        end
        Reset = 1'b0;
        #1;
        check_ctrl("rstwait_outputs", E_RST);
        @(posedge Clock); #1;
        exp_stall = 0;
        check_stall("rstwait_stall");
        @(negedge Clock);
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
        #1;
        check_ctrl("rstwait_run", E_BR);
        @(posedge Clock); #1;
        check_stall("rstwait_run_stall");

        // Fresh access after reset must take the full 15-cycle wait again
        for (int c = 1; c <= 16; c++) begin
            @(negedge Clock);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
            #1;
            check_ctrl($sformatf("rst_cnt_c%0d", c), (c == 16) ? E_TO : E_MS);
        end
        exp_stall += 15;
        @(negedge Clock);
        drive_idle();
        @(posedge Clock); #1;
        check_stall("rst_cnt_stall");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
